// File: rtl/f2f_pkg.sv
// Shared widths and the capture-stage record for the float-to-fixed arbiter.
// Widths here are the build defaults; the S1 record is sized from them.
package f2f_pkg;
    localparam int FLOATSIZE      = 32;
    localparam int FIXEDSIZE      = 64;
    localparam int RADIXPOINTSIZE = 6;
    localparam int EXPONENTBITS   = 8;
    localparam int MANTISSABITS   = 23;
    localparam int MAXIDW         = 4;   // enough for 16 requesters

    typedef struct packed {
        logic [FLOATSIZE-1:0]      floatVal;
        logic [RADIXPOINTSIZE-1:0] radix;
        logic [MAXIDW-1:0]         id;
    } f2f_req_t;
endpackage

// File: rtl/float2fixed.sv
// Combinational IEEE-754 to two's-complement fixed point: value * 2^radix, truncated.
// Latency 0; no handshake. Inf/NaN raise OutException and zero the result.
// Denormals flush to zero; OutOverflow holds magnitude bits above FIXEDSIZE.
module Float2Fixed #(
    parameter int FLOATSIZE      = f2f_pkg::FLOATSIZE,
    parameter int FIXEDSIZE      = f2f_pkg::FIXEDSIZE,
    parameter int RADIXPOINTSIZE = f2f_pkg::RADIXPOINTSIZE,
    parameter int EXPONENTBITS   = f2f_pkg::EXPONENTBITS,
    parameter int MANTISSABITS   = f2f_pkg::MANTISSABITS
) (
    input  logic [FLOATSIZE-1:0]      InFloat,
    input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
    output logic [FIXEDSIZE-1:0]      OutFixed,
    output logic [RADIXPOINTSIZE-1:0] OutOverflow,
    output logic                      OutException
);
    localparam int BIAS = (1 << (EXPONENTBITS - 1)) - 1;
    localparam int W    = FIXEDSIZE + RADIXPOINTSIZE;

    logic                    sign;
    logic [EXPONENTBITS-1:0] expField;
    logic [W-1:0]            ext, mag;
    logic [FIXEDSIZE-1:0]    fixedMag;
    logic                    ovf;
    int                      sh;

    always_comb begin
        sign     = InFloat[FLOATSIZE-1];
        expField = InFloat[FLOATSIZE-2 -: EXPONENTBITS];
        ext      = {{(W-MANTISSABITS-1){1'b0}}, 1'b1, InFloat[MANTISSABITS-1:0]};
        sh       = int'(expField) + int'(InRadixPoint) - BIAS - MANTISSABITS;
        mag      = '0;
        ovf      = 1'b0;
        if (expField != '0) begin
            if (sh >= 0) begin
                ovf = (sh > W - MANTISSABITS - 1);
                mag = ext << sh;
            end else if (sh > -(MANTISSABITS + 1)) begin
                mag = ext >> (-sh);
            end
        end
        fixedMag     = mag[FIXEDSIZE-1:0];
        OutException = &expField;
        if (OutException) begin
            OutFixed    = '0;
            OutOverflow = '0;
        end else begin
            OutFixed    = sign ? (~fixedMag + 1'b1) : fixedMag;
            OutOverflow = ovf ? '1 : mag[W-1:FIXEDSIZE];
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or above ptr, with wrap.
// Latency 0; grant is forced to zero when enable is low.
// Backpressure: the caller expresses it through enable.
module rr_arbiter #(
    parameter int NUMREQ = 4,
    parameter int IDW    = $clog2(NUMREQ)
) (
    input  logic [NUMREQ-1:0] req,
    input  logic [IDW-1:0]    ptr,
    input  logic              enable,
    output logic [NUMREQ-1:0] gnt,
    output logic [IDW-1:0]    winner
);
    logic found;
    int   idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        gnt    = '0;
        idx    = 0;
        for (int off = 0; off < NUMREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUMREQ) idx = idx - NUMREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
        if (enable && found) gnt[winner] = 1'b1;
    end
endmodule

// File: rtl/float2fixed_arbiter.sv
// Round-robin shares one Float2Fixed among NUMREQ clients; sticky exceptions under F2F_ARB_STICKY_EXC_EN.
// Latency: accept at edge k, result registered at edge k+1; one result per cycle.
// Backpressure: InReady low stalls S2, then S1; OutGnt drops to 0 once both are full.
module float2fixed_arbiter
    import f2f_pkg::*;
#(
    parameter int FLOATSIZE      = f2f_pkg::FLOATSIZE,
    parameter int FIXEDSIZE      = f2f_pkg::FIXEDSIZE,
    parameter int RADIXPOINTSIZE = f2f_pkg::RADIXPOINTSIZE,
    parameter int EXPONENTBITS   = f2f_pkg::EXPONENTBITS,
    parameter int MANTISSABITS   = f2f_pkg::MANTISSABITS,
    parameter int NUMREQ         = 4,
    parameter int IDW            = $clog2(NUMREQ)
) (
    input  logic                             Clk,
    input  logic                             Rst_n,
    input  logic [NUMREQ-1:0]                InReq,
    input  logic [NUMREQ*FLOATSIZE-1:0]      InFloat,
    input  logic [NUMREQ*RADIXPOINTSIZE-1:0] InRadixPoint,
    output logic [NUMREQ-1:0]                OutGnt,
    output logic                             OutValid,
    input  logic                             InReady,
    output logic [FIXEDSIZE-1:0]             OutFixed,
    output logic [RADIXPOINTSIZE-1:0]        OutOverflow,
    output logic                             OutException,
    output logic [IDW-1:0]                   OutId,
    input  logic [NUMREQ-1:0]                InExcClear,
    output logic [NUMREQ-1:0]                OutExcSticky
);
    f2f_req_t                  s1Req;
    logic                      s1Valid, s1CanLoad, s2Load, anyGnt;
    logic [IDW-1:0]            ptr, winner;
    logic [FIXEDSIZE-1:0]      convFixed;
    logic [RADIXPOINTSIZE-1:0] convOverflow;
    logic                      convException;
    logic                      unusedIdBits;

    assign s2Load    = s1Valid & (~OutValid | InReady);
    assign s1CanLoad = ~s1Valid | s2Load;
    assign anyGnt    = |OutGnt;
    assign unusedIdBits = ^s1Req.id;

    // Rst_n gates the enable so no grant can be seen while reset is held.
    rr_arbiter #(.NUMREQ(NUMREQ), .IDW(IDW)) uArb (
        .req    (InReq),
        .ptr    (ptr),
        .enable (s1CanLoad & Rst_n),
        .gnt    (OutGnt),
        .winner (winner)
    );

    Float2Fixed #(
        .FLOATSIZE      (FLOATSIZE),
        .FIXEDSIZE      (FIXEDSIZE),
        .RADIXPOINTSIZE (RADIXPOINTSIZE),
        .EXPONENTBITS   (EXPONENTBITS),
        .MANTISSABITS   (MANTISSABITS)
    ) uConv (
        .InFloat      (s1Req.floatVal),
        .InRadixPoint (s1Req.radix),
        .OutFixed     (convFixed),
        .OutOverflow  (convOverflow),
        .OutException (convException)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1Valid <= 1'b0;
            s1Req   <= '0;
            ptr     <= '0;
        end else if (anyGnt) begin
            s1Valid        <= 1'b1;
            s1Req.floatVal <= InFloat[winner*FLOATSIZE +: FLOATSIZE];
            s1Req.radix    <= InRadixPoint[winner*RADIXPOINTSIZE +: RADIXPOINTSIZE];
            s1Req.id       <= MAXIDW'(winner);
            ptr            <= (int'(winner) == NUMREQ - 1) ? '0 : winner + 1'b1;
        end else if (s2Load) begin
            s1Valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutValid     <= 1'b0;
            OutFixed     <= '0;
            OutOverflow  <= '0;
            OutException <= 1'b0;
            OutId        <= '0;
        end else if (s2Load) begin
            OutValid     <= 1'b1;
            OutFixed     <= convFixed;
            OutOverflow  <= convOverflow;
            OutException <= convException;
            OutId        <= s1Req.id[IDW-1:0];
        end else if (InReady) begin
            OutValid <= 1'b0;
        end
    end

`ifdef F2F_ARB_STICKY_EXC_EN
    logic [NUMREQ-1:0] excSet;

    always_comb begin
        excSet = '0;
        if (OutValid && InReady && OutException) excSet[OutId] = 1'b1;
    end

    // Set is OR-ed after the clear so a same-edge set survives.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) OutExcSticky <= '0;
        else        OutExcSticky <= (OutExcSticky & ~InExcClear) | excSet;
    end
`else
    logic unusedExcClear;
    assign unusedExcClear = ^InExcClear;
    assign OutExcSticky   = '0;
`endif
endmodule

// File: tb/tb_float2fixed_arbiter.sv
// Directed bench for float2fixed_arbiter (NUMREQ=4, default widths).
module tb_float2fixed_arbiter;
    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [3:0]   InReq, OutGnt, InExcClear, OutExcSticky;
    logic [127:0] InFloat;
    logic [23:0]  InRadixPoint;
    logic         OutValid, InReady, OutException;
    logic [63:0]  OutFixed;
    logic [5:0]   OutOverflow;
    logic [1:0]   OutId;
    int nVec = 0;
    int nErr = 0;

`ifdef F2F_ARB_STICKY_EXC_EN
    localparam logic [3:0] STK_EXP = 4'b0100;
`else
    localparam logic [3:0] STK_EXP = 4'b0000;
`endif

    always #5 Clk = ~Clk;

    float2fixed_arbiter dut (
        .Clk(Clk), .Rst_n(Rst_n), .InReq(InReq), .InFloat(InFloat),
        .InRadixPoint(InRadixPoint), .OutGnt(OutGnt), .OutValid(OutValid),
        .InReady(InReady), .OutFixed(OutFixed), .OutOverflow(OutOverflow),
        .OutException(OutException), .OutId(OutId), .InExcClear(InExcClear),
        .OutExcSticky(OutExcSticky)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic setOp(input int i, input logic [31:0] f, input logic [5:0] r);
        InFloat[i*32 +: 32]     = f;
        InRadixPoint[i*6 +: 6]  = r;
    endtask

    task automatic doReset();
        InReq = '0; InExcClear = '0; InReady = 1'b1;
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        InFloat = '0; InRadixPoint = '0; InExcClear = '0; InReady = 1'b1;
        InReq = 4'b1111;
        Rst_n = 1'b0;
        #2;
        nVec++; if (OutGnt !== 4'b0000) begin nErr++; $display("FAIL rst_gnt: got %b want 0000", OutGnt); end
        nVec++; if (OutValid !== 1'b0) begin nErr++; $display("FAIL rst_valid: got %b want 0", OutValid); end
        nVec++; if (OutFixed !== 64'd0) begin nErr++; $display("FAIL rst_fixed: got %h want 0", OutFixed); end
        nVec++; if (OutId !== 2'd0 || OutException !== 1'b0 || OutOverflow !== 6'd0) begin nErr++; $display("FAIL rst_misc: id %0d exc %b ovf %h want 0 0 0", OutId, OutException, OutOverflow); end
        nVec++; if (OutExcSticky !== 4'b0000) begin nErr++; $display("FAIL rst_sticky: got %b want 0000", OutExcSticky); end
        InReq = '0;
        #1;
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        setOp(0, 32'h3F800000, 6'd16);
        InReq = 4'b0001;
        #1;
        nVec++; if (OutGnt !== 4'b0001) begin nErr++; $display("FAIL single_gnt: got %b want 0001", OutGnt); end
        step();
        InReq = '0;
        nVec++; if (OutValid !== 1'b0) begin nErr++; $display("FAIL single_early: OutValid %b want 0", OutValid); end
        step();
        nVec++; if (OutValid !== 1'b1 || OutFixed !== 64'h10000) begin nErr++; $display("FAIL single_res: valid %b fixed %h want 1 10000", OutValid, OutFixed); end
        nVec++; if (OutId !== 2'd0 || OutException !== 1'b0 || OutOverflow !== 6'd0) begin nErr++; $display("FAIL single_meta: id %0d exc %b ovf %h want 0 0 0", OutId, OutException, OutOverflow); end
        step();
        nVec++; if (OutValid !== 1'b0) begin nErr++; $display("FAIL single_drain: OutValid %b want 0", OutValid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        int eid;
        doReset();
        for (int i = 0; i < 4; i++) setOp(i, 32'h40200000, 6'd4);
        InReq = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            eg = 4'b0001 << (c % 4);
            nVec++; if (OutGnt !== eg) begin nErr++; $display("FAIL rr_gnt c%0d: got %b want %b", c, OutGnt, eg); end
            if (c >= 2) begin
                eid = (c - 2) % 4;
                nVec++; if (OutValid !== 1'b1 || OutId !== eid[1:0] || OutFixed !== 64'h28) begin nErr++; $display("FAIL rr_res c%0d: valid %b id %0d fixed %h want 1 %0d 28", c, OutValid, OutId, OutFixed, eid); end
            end
            step();
        end
        InReq = '0;
        step(); step(); step();
    endtask

    task automatic test_back_pressure();
        int acc;
        doReset();
        setOp(0, 32'h3F800000, 6'd0);
        setOp(1, 32'h40000000, 6'd0);
        setOp(2, 32'h40400000, 6'd0);
        setOp(3, 32'h40800000, 6'd0);
        InReady = 1'b0;
        InReq = 4'b1111;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            acc += $countones(InReq & OutGnt);
            if (c >= 2) begin
                nVec++; if (OutGnt !== 4'b0000) begin nErr++; $display("FAIL bp_stall c%0d: gnt %b want 0000", c, OutGnt); end
                nVec++; if (OutValid !== 1'b1 || OutId !== 2'd0 || OutFixed !== 64'd1) begin nErr++; $display("FAIL bp_hold c%0d: valid %b id %0d fixed %h want 1 0 1", c, OutValid, OutId, OutFixed); end
            end
            step();
        end
        nVec++; if (acc != 2) begin nErr++; $display("FAIL bp_accepted: got %0d want 2", acc); end
        InReady = 1'b1;
        #1;
        nVec++; if (OutGnt !== 4'b0100) begin nErr++; $display("FAIL bp_nobubble: gnt %b want 0100", OutGnt); end
        nVec++; if (OutId !== 2'd0 || OutFixed !== 64'd1) begin nErr++; $display("FAIL bp_drain0: id %0d fixed %h want 0 1", OutId, OutFixed); end
        step();
        InReq = '0;
        nVec++; if (OutValid !== 1'b1 || OutId !== 2'd1 || OutFixed !== 64'd2) begin nErr++; $display("FAIL bp_drain1: valid %b id %0d fixed %h want 1 1 2", OutValid, OutId, OutFixed); end
        step();
        nVec++; if (OutValid !== 1'b1 || OutId !== 2'd2 || OutFixed !== 64'd3) begin nErr++; $display("FAIL bp_drain2: valid %b id %0d fixed %h want 1 2 3", OutValid, OutId, OutFixed); end
        step();
        nVec++; if (OutValid !== 1'b0) begin nErr++; $display("FAIL bp_empty: valid %b want 0", OutValid); end
    endtask

    task automatic test_special();
        setOp(2, 32'h7F800000, 6'd8);
        InReq = 4'b0100;
        #1;
        nVec++; if (OutGnt !== 4'b0100) begin nErr++; $display("FAIL sp_gnt_inf: got %b want 0100", OutGnt); end
        step();
        setOp(1, 32'h00000000, 6'd8);
        InReq = 4'b0010;
        #1;
        nVec++; if (OutGnt !== 4'b0010) begin nErr++; $display("FAIL sp_gnt_zero: got %b want 0010", OutGnt); end
        step();
        InReq = '0;
        nVec++; if (OutValid !== 1'b1 || OutException !== 1'b1 || OutId !== 2'd2 || OutFixed !== 64'd0) begin nErr++; $display("FAIL sp_inf: valid %b exc %b id %0d fixed %h want 1 1 2 0", OutValid, OutException, OutId, OutFixed); end
        step();
        nVec++; if (OutValid !== 1'b1 || OutException !== 1'b0 || OutId !== 2'd1 || OutFixed !== 64'd0) begin nErr++; $display("FAIL sp_zero: valid %b exc %b id %0d fixed %h want 1 0 1 0", OutValid, OutException, OutId, OutFixed); end
        nVec++; if (OutExcSticky !== STK_EXP) begin nErr++; $display("FAIL sp_sticky: got %b want %b", OutExcSticky, STK_EXP); end
        step();
        nVec++; if (OutValid !== 1'b0) begin nErr++; $display("FAIL sp_empty: valid %b want 0", OutValid); end
    endtask

    task automatic test_sticky();
        InExcClear = 4'b0100;
        step();
        InExcClear = '0;
        nVec++; if (OutExcSticky !== 4'b0000) begin nErr++; $display("FAIL stk_clear: got %b want 0000", OutExcSticky); end
        InReq = 4'b0100;
        step();
        InReq = '0;
        step();
        InExcClear = 4'b0100;
        nVec++; if (OutValid !== 1'b1 || OutException !== 1'b1) begin nErr++; $display("FAIL stk_pre: valid %b exc %b want 1 1", OutValid, OutException); end
        step();
        InExcClear = '0;
        nVec++; if (OutExcSticky !== STK_EXP) begin nErr++; $display("FAIL stk_setwins: got %b want %b", OutExcSticky, STK_EXP); end
        InExcClear = 4'b0100;
        step();
        InExcClear = '0;
    endtask

    task automatic test_reset_midstream();
        setOp(0, 32'h3F800000, 6'd0);
        setOp(1, 32'h40000000, 6'd0);
        InReady = 1'b0;
        InReq = 4'b1111;
        step(); step(); step();
        nVec++; if (OutValid !== 1'b1 || OutGnt !== 4'b0000) begin nErr++; $display("FAIL mr_full: valid %b gnt %b want 1 0000", OutValid, OutGnt); end
        Rst_n = 1'b0;
        #1;
        nVec++; if (OutValid !== 1'b0 || OutGnt !== 4'b0000) begin nErr++; $display("FAIL mr_rst: valid %b gnt %b want 0 0000", OutValid, OutGnt); end
        nVec++; if (OutFixed !== 64'd0 || OutId !== 2'd0 || OutException !== 1'b0 || OutExcSticky !== 4'b0000) begin nErr++; $display("FAIL mr_outs: fixed %h id %0d exc %b stk %b want 0", OutFixed, OutId, OutException, OutExcSticky); end
        InReady = 1'b1;
        #1;
        Rst_n = 1'b1;
        #1;
        nVec++; if (OutGnt !== 4'b0001) begin nErr++; $display("FAIL mr_first_gnt: got %b want 0001", OutGnt); end
        step();
        InReq = '0;
        nVec++; if (OutValid !== 1'b0) begin nErr++; $display("FAIL mr_nopartial: valid %b want 0", OutValid); end
        step();
        nVec++; if (OutValid !== 1'b1 || OutId !== 2'd0 || OutFixed !== 64'd1) begin nErr++; $display("FAIL mr_after: valid %b id %0d fixed %h want 1 0 1", OutValid, OutId, OutFixed); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_special();
        test_sticky();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
